estagio_resultado_mult: RTL and testbench
=========================================

// Module: estagio_resultado_mult
// PURPOSE
//   Registered result stage directly downstream of the 8-bit combinational multiplier.
//   Captures product p[7:0] and overflow ov with a valid/ready handshake.
//   Buffers up to DEPTH results, derives status flags and keeps overflow statistics.
//   Presents results to the ALU output/flag logic through a second valid/ready interface.
// PARAMETERS
//   WIDTH   8   data width of product and result (matches multiplier output)
//   DEPTH   2   buffer entries; legal values 2 or 4 (power of two)
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst_n       in   1      asynchronous, active-low reset
//   p           in   WIDTH  product from multiplier
//   ov          in   1      overflow from multiplier
//   in_valid    in   1      p/ov valid this cycle
//   in_ready    out  1      stage can accept an entry
//   res         out  WIDTH  result at buffer head
//   flag_z      out  1      res == 0
//   flag_n      out  1      res[WIDTH-1]
//   flag_ov     out  1      overflow bit stored with head entry
//   out_valid   out  1      head entry valid
//   out_ready   in   1      consumer accepts head entry
//   clr_sticky  in   1      clears ov_sticky and ov_cnt
//   ov_sticky   out  1      set by any accepted entry with ov=1
//   ov_cnt      out  8      count of accepted ov=1 entries, saturates at 255
// BEHAVIOUR
//   - Reset (rst_n=0, async): buffer empty, rd/wr pointers 0, out_valid=0, in_ready=1,
//     res=0, flag_z=1, flag_n=0, flag_ov=0, ov_sticky=0, ov_cnt=0.
//   - Occupancy states: EMPTY (cnt=0), PARTIAL (0<cnt<DEPTH), FULL (cnt=DEPTH).
//     push = in_valid & in_ready; pop = out_valid & out_ready.
//     EMPTY: push -> PARTIAL. PARTIAL: push&!pop -> cnt+1 (FULL at DEPTH);
//     pop&!push -> cnt-1 (EMPTY at 0); push&pop -> cnt unchanged. FULL: pop -> PARTIAL.
//   - in_ready = (cnt != DEPTH); registered-state function, no dependency on out_ready.
//     FULL with pop in same cycle: no push that cycle; in_ready rises the next cycle.
//   - out_valid = (cnt != 0). Latency: entry pushed at edge N is visible on res/out_valid
//     after edge N (one cycle, no combinational path from p to res).
//   - res/flag_ov/flag_z/flag_n driven from head entry; held stable while out_valid=1
//     and out_ready=0. Flags combinational from head entry only.
//   - Pointers wrap modulo DEPTH; push and pop on same entry index never coincide.
//   - ov_sticky: set on push with ov=1; cleared by clr_sticky; set and clear in the
//     same cycle -> set wins (ov_sticky=1, ov_cnt=1).
//   - ov_cnt: +1 on push with ov=1, holds at 255; clr_sticky sets it to 0 (or 1 if
//     simultaneous ov push).
//   - in_valid while in_ready=0: p/ov ignored, no state change.
//   - Reset mid-operation: all buffered entries discarded, return to reset values.
// CONFIGURATION
//   RESULT_SAT_EN defined: entries pushed with ov=1 store res = all ones (8'hFF),
//     flag_ov=1; flag_z=0, flag_n=1 follow from stored value.
//   RESULT_SAT_EN undefined: res stores p unchanged (truncated low bits); flag_ov still 1.
// TESTING
//   1. Reset: rst_n=0 mid-stream with 2 entries held -> out_valid=0, in_ready=1,
//      res=0, flag_z=1, ov_cnt=0 immediately (before next clock edge).
//   2. Single push p=8'h2A ov=0, out_ready=0 -> next cycle res=8'h2A, out_valid=1,
//      flag_z=0, flag_n=0; held for 5 cycles; out_ready=1 -> out_valid=0 next cycle.
//   3. Fill: push 8'h01, 8'h02 with out_ready=0 -> in_ready=0; extra in_valid with 8'h03
//      ignored; drain yields 8'h01, 8'h02 in order, then out_valid=0.
//   4. Streaming: in_valid=1, out_ready=1 every cycle, p=0..9 -> res sequence 0..9,
//      one per cycle, in_ready stays 1, first flag_z=1.
//   5. Overflow: push p=8'h40 ov=1 -> flag_ov=1, ov_sticky=1, ov_cnt=1; res=8'hFF with
//      RESULT_SAT_EN, 8'h40 without; 300 ov pushes -> ov_cnt=255.
//   6. clr_sticky coincident with ov=1 push -> ov_sticky=1, ov_cnt=1; clr_sticky alone
//      next cycle -> ov_sticky=0, ov_cnt=0.

Source files
------------

// File: rtl/estagio_resultado_mult.sv
// Result stage after the 8-bit multiplier: DEPTH-entry buffer, status flags and overflow statistics.
// Optional RESULT_SAT_EN: entries pushed with ov=1 are stored saturated to all ones.
module estagio_resultado_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] p,
    input  logic             ov,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_ov,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_sticky,
    output logic             ov_sticky,
    output logic [7:0]       ov_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_t;

    occ_t             state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic             mem_ov   [DEPTH];
    logic [WIDTH-1:0] din;
    logic             push, pop;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

`ifdef RESULT_SAT_EN
    assign din = ov ? {WIDTH{1'b1}} : p;
`else
    assign din = p;
`endif

    // Occupancy state and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (push) wr_ptr <= PTR_W'(wr_ptr + PTR_W'(1));
            if (pop)  rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            EMPTY: begin
                if (push) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = PARTIAL;
                end
            end
            PARTIAL: begin
                if (push && !pop) begin
                    cnt_nxt = CNT_W'(cnt + CNT_W'(1));
                    if (cnt == CNT_W'(DEPTH - 1)) state_nxt = FULL;
                end else if (pop && !push) begin
                    cnt_nxt = CNT_W'(cnt - CNT_W'(1));
                    if (cnt == CNT_W'(1)) state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    cnt_nxt   = CNT_W'(cnt - CNT_W'(1));
                    state_nxt = PARTIAL;
                end
            end
            default: begin
                state_nxt = EMPTY;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Entry storage; contents are masked while empty, so no reset needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= din;
            mem_ov[wr_ptr]   <= ov;
        end
    end

    assign res     = out_valid ? mem_data[rd_ptr] : '0;
    assign flag_z  = (res == '0);
    assign flag_n  = res[WIDTH-1];
    assign flag_ov = out_valid & mem_ov[rd_ptr];

    // Overflow statistics; an ov push in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_sticky <= 1'b0;
            ov_cnt    <= 8'd0;
        end else begin
            if (push && ov)      ov_sticky <= 1'b1;
            else if (clr_sticky) ov_sticky <= 1'b0;

            if (clr_sticky)                          ov_cnt <= (push && ov) ? 8'd1 : 8'd0;
            else if (push && ov && ov_cnt != 8'hFF)  ov_cnt <= 8'(ov_cnt + 8'd1);
        end
    end

endmodule

// File: tb/tb_estagio_resultado_mult.sv
// Directed bench for estagio_resultado_mult; honours RESULT_SAT_EN for saturation expectations.
module tb_estagio_resultado_mult;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p;
    logic       ov;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] res;
    logic       flag_z, flag_n, flag_ov;
    logic       out_valid;
    logic       out_ready;
    logic       clr_sticky;
    logic       ov_sticky;
    logic [7:0] ov_cnt;

    int checks = 0;
    int passed = 0;

    estagio_resultado_mult #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .p(p), .ov(ov), .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .flag_z(flag_z), .flag_n(flag_n), .flag_ov(flag_ov), .out_valid(out_valid),
        .out_ready(out_ready), .clr_sticky(clr_sticky), .ov_sticky(ov_sticky), .ov_cnt(ov_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ov_res;
        logic       ov_neg;
`ifdef RESULT_SAT_EN
        ov_res = 8'hFF;
        ov_neg = 1'b1;
`else
        ov_res = 8'h40;
        ov_neg = 1'b0;
`endif
        rst_n = 1'b0; p = '0; ov = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res", res, 0);
        check("rst_flag_z", flag_z, 1);
        check("rst_flag_ov", flag_ov, 0);
        check("rst_ov_cnt", ov_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // single push held with out_ready low
        p = 8'h2A; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("single_res", res, 8'h2A);
        check("single_valid", out_valid, 1);
        check("single_z", flag_z, 0);
        check("single_n", flag_n, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("single_hold", res, 8'h2A);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("single_drained", out_valid, 0);

        // fill, ignored extra, drain in order
        in_valid = 1'b1; p = 8'h01;
        step();
        p = 8'h02;
        step();
        check("fill_in_ready", in_ready, 0);
        p = 8'h03;
        step();
        in_valid = 1'b0;
        check("fill_head", res, 8'h01);
        out_ready = 1'b1;
        step();
        check("drain_second", res, 8'h02);
        check("drain_second_valid", out_valid, 1);
        step();
        check("drain_empty", out_valid, 0);
        check("drain_in_ready", in_ready, 1);

        // streaming
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            p = 8'(i);
            step();
            check("stream_res", res, i);
            check("stream_in_ready", in_ready, 1);
            if (i == 0) check("stream_first_z", flag_z, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end", out_valid, 0);

        // overflow
        out_ready = 1'b0;
        p = 8'h40; ov = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("ov_flag", flag_ov, 1);
        check("ov_sticky", ov_sticky, 1);
        check("ov_cnt1", ov_cnt, 1);
        check("ov_res", res, ov_res);
        check("ov_flag_n", flag_n, ov_neg);
        check("ov_flag_z", flag_z, 0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 253; i++) step();
        check("ov_cnt254", ov_cnt, 254);
        step();
        check("ov_cnt255", ov_cnt, 255);
        for (int i = 0; i < 45; i++) step();
        check("ov_cnt_sat", ov_cnt, 255);
        in_valid = 1'b0; ov = 1'b0;
        step();
        check("ov_drained", out_valid, 0);

        // reset mid-stream with two held entries
        out_ready = 1'b0; in_valid = 1'b1; p = 8'h11;
        step();
        p = 8'h22;
        step();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_res", res, 0);
        check("mid_rst_z", flag_z, 1);
        check("mid_rst_cnt", ov_cnt, 0);
        check("mid_rst_sticky", ov_sticky, 0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // clear coincident with ov push
        out_ready = 1'b1; in_valid = 1'b1; ov = 1'b1; p = 8'h05;
        step();
        check("pre_clr_cnt", ov_cnt, 1);
        clr_sticky = 1'b1;
        step();
        check("clr_coinc_sticky", ov_sticky, 1);
        check("clr_coinc_cnt", ov_cnt, 1);
        in_valid = 1'b0; ov = 1'b0;
        step();
        clr_sticky = 1'b0;
        check("clr_sticky", ov_sticky, 0);
        check("clr_cnt", ov_cnt, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
